n64_pi_burst_port: RTL and testbench

Parametrised next-generation N64 PI cartridge bus slave. Replaces the fixed 16-bit read-only front end with a windowed read/write port that has a prefetch FIFO. It decodes the multiplexed AD bus (ALE_H/ALE_L address phases, READ_N/WRITE_N data strobes) and turns bursts into word requests on a generic memory port (SDRAM/BRAM controller side). The AD pad tristate stays at the top level; this block exposes separate in, out and enable signals.

---
 rtl/n64_pi_burst_port.sv | 165 ++++++++++++++++
 tb/tb_n64_pi_burst_port.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/n64_pi_burst_port.sv
// n64_pi_burst_port: windowed read/write N64 PI cartridge slave with read prefetch FIFO on a generic memory port
module n64_pi_burst_port #(
  parameter int AD_W = 16,
  parameter int ADDR_W = 32,
  parameter int MEM_ADDR_W = 26,
  parameter logic [ADDR_W-1:0] BASE = 32'h1000_0000,
  parameter logic [ADDR_W-1:0] MASK = 32'hFC00_0000,
  parameter int FIFO_DEPTH = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  N64_ALE_H,
  input  logic                  N64_ALE_L,
  input  logic                  N64_READ_N,
  input  logic                  N64_WRITE_N,
  input  logic [AD_W-1:0]       N64_AD_I,
  output logic [AD_W-1:0]       N64_AD_O,
  output logic                  N64_AD_OE,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [MEM_ADDR_W-1:0] mem_addr,
  output logic [AD_W-1:0]       mem_wdata,
  input  logic                  mem_ready,
  input  logic                  mem_rvalid,
  input  logic [AD_W-1:0]       mem_rdata,
  output logic                  underrun
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int SH = $clog2(AD_W / 8);
  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(AD_W / 8);
  typedef enum logic [2:0] {IDLE, ADDR_H, ACTIVE, MISS, FLUSH} state_t;
  state_t state, state_n;
  logic [SYNC_STAGES-1:0][3:0] cs;
  logic [SYNC_STAGES-1:0][AD_W-1:0] ds;
  logic [3:0] prev, cur;
  logic [AD_W-1:0] ad;
  logic ale_h_fall, ale_l_fall, ale_l_rise, rd_fall, rd_rise, wr_rise;
  logic [ADDR_W-AD_W-1:0] addr_h;
  logic [ADDR_W-1:0] full, rd_ptr, rd_ptr_n, dptr, dptr_n, waddr, baddr;
  logic [AD_W-1:0] wdata, bdata;
  logic [AD_W-1:0] fifo [FIFO_DEPTH];
  logic [PW-1:0] wp, rp;
  logic [CW-1:0] count, inflight, inflight_n, drop, drop_n;
  logic [CW:0] occ;
  logic active, hit, latch_l, rd_rise_a, wr_rise_a, wv, bv, pf_ok, wr_acc, rd_acc, flush, rv, push, pop;
  function automatic logic [MEM_ADDR_W-1:0] idx(input logic [ADDR_W-1:0] a);
    return MEM_ADDR_W'((a & ~MASK) >> SH);
  endfunction
  assign cur = cs[SYNC_STAGES-1];
  assign ad = ds[SYNC_STAGES-1];
  assign ale_h_fall = prev[3] & ~cur[3];
  assign ale_l_fall = prev[2] & ~cur[2];
  assign ale_l_rise = ~prev[2] & cur[2];
  assign rd_fall = prev[1] & ~cur[1];
  assign rd_rise = ~prev[1] & cur[1];
  assign wr_rise = ~prev[0] & cur[0];
  assign active = state == ACTIVE;
  assign full = {addr_h, ad};
  assign hit = (full & MASK) == BASE;
  assign latch_l = (state == ADDR_H) & ale_l_fall;
  assign rd_rise_a = active & rd_rise;
  assign wr_rise_a = active & wr_rise;
  assign occ = {1'b0, count} + {1'b0, inflight};
  assign pf_ok = active & (occ < (CW+1)'(FIFO_DEPTH));
  assign wr_acc = wv & mem_ready;
  assign rd_acc = pf_ok & ~wv & mem_ready;
  assign flush = (state == FLUSH) | wr_acc;
  assign rv = mem_rvalid & (inflight != '0);
  assign push = rv & ~flush & (drop == '0);
  assign pop = rd_rise_a & (count != '0);
  assign inflight_n = inflight + CW'(rd_acc) - CW'(rv);
  assign drop_n = flush ? inflight_n : drop - CW'(rv && drop != '0);
  assign dptr_n = latch_l ? full : dptr + (rd_rise_a ? STEP : '0) + (wr_rise_a ? STEP : '0);
  assign rd_ptr_n = latch_l ? full : wr_acc ? dptr_n : rd_acc ? rd_ptr + STEP : rd_ptr;
  assign mem_req = wv | pf_ok;
  assign mem_we = wv;
  assign mem_addr = idx(wv ? waddr : rd_ptr);
  assign mem_wdata = wdata;
  assign N64_AD_O = (count != '0) ? fifo[rp] : '0;
  assign N64_AD_OE = active & ~cur[1];
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (ale_h_fall) state_n = ADDR_H;
      ADDR_H:  if (ale_l_fall) state_n = hit ? ACTIVE : MISS;
      ACTIVE:  if (ale_l_rise) state_n = FLUSH;
      MISS:    if (ale_l_rise) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!resetn) begin
      cs <= '0;
      ds <= '0;
      prev <= '0;
    end else begin
      cs[0] <= {N64_ALE_H, N64_ALE_L, N64_READ_N, N64_WRITE_N};
      ds[0] <= N64_AD_I;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        cs[i] <= cs[i-1];
        ds[i] <= ds[i-1];
      end
      prev <= cur;
    end
  end
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= IDLE;
      addr_h <= '0;
      rd_ptr <= '0;
      dptr <= '0;
      wv <= 1'b0;
      bv <= 1'b0;
      waddr <= '0;
      wdata <= '0;
      baddr <= '0;
      bdata <= '0;
      count <= '0;
      wp <= '0;
      rp <= '0;
      inflight <= '0;
      drop <= '0;
      underrun <= 1'b0;
    end else begin
      state <= state_n;
      if ((state == IDLE) && ale_h_fall) addr_h <= (ADDR_W-AD_W)'(ad);
      rd_ptr <= rd_ptr_n;
      dptr <= dptr_n;
      inflight <= inflight_n;
      drop <= drop_n;
      underrun <= underrun | (active & rd_fall & (count == '0));
      if (wv && !wr_acc) begin
        if (!bv && wr_rise_a) begin
          bv <= 1'b1;
          baddr <= dptr;
          bdata <= ad;
        end
      end else begin
        wv <= bv | wr_rise_a;
        bv <= bv & wr_rise_a;
        if (bv) begin
          waddr <= baddr;
          wdata <= bdata;
          baddr <= dptr;
          bdata <= ad;
        end else if (wr_rise_a) begin
          waddr <= dptr;
          wdata <= ad;
        end
      end
      if (flush) begin
        count <= '0;
        wp <= '0;
        rp <= '0;
      end else begin
        count <= count + CW'(push) - CW'(pop);
        if (push) wp <= wp + PW'(1);
        if (pop) rp <= rp + PW'(1);
      end
    end
  end
  always_ff @(posedge clk) if (push) fifo[wp] <= mem_rdata;
endmodule

// File: tb/tb_n64_pi_burst_port.sv
// tb_n64_pi_burst_port: scoreboard bench for the PI burst port with an in-order latency memory model
module tb_n64_pi_burst_port;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic ale_h = 1'b1, ale_l = 1'b1, read_n = 1'b1, write_n = 1'b1;
  logic [15:0] ad_i = '0;
  logic [15:0] ad_o;
  logic ad_oe, mem_req, mem_we, mem_ready = 1'b1, mem_rvalid = 1'b0, underrun;
  logic [25:0] mem_addr;
  logic [15:0] mem_wdata, mem_rdata = '0;
  int checks = 0, passes = 0, lat = 2, cyc = 0, miss_viol = 0;
  logic in_miss = 1'b0;
  logic [25:0] pq[$];
  int pd[$];
  logic [41:0] exp_wr[$];
  logic [16:0] exp_rd[$];
  logic [25:0] base_q[$];
  logic [15:0] exp4 [4] = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
  always #5 clk = ~clk;
  n64_pi_burst_port dut (
    .clk(clk), .resetn(resetn),
    .N64_ALE_H(ale_h), .N64_ALE_L(ale_l), .N64_READ_N(read_n), .N64_WRITE_N(write_n),
    .N64_AD_I(ad_i), .N64_AD_O(ad_o), .N64_AD_OE(ad_oe),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .underrun(underrun)
  );
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
  endtask
  function automatic logic [15:0] mdata(input logic [25:0] i);
    return (i < 26'd4) ? 16'((i + 26'd1) * 26'h1111) : (i[15:0] ^ 16'hA5A5);
  endfunction
  initial forever begin
    @(negedge clk);
    cyc++;
    if (pq.size() > 0 && pd[0] <= cyc) begin
      mem_rvalid = 1'b1;
      mem_rdata = mdata(pq.pop_front());
      void'(pd.pop_front());
    end else begin
      mem_rvalid = 1'b0;
      mem_rdata = '0;
    end
    if (mem_req && mem_ready && !mem_we) begin
      pq.push_back(mem_addr);
      pd.push_back(cyc + lat);
    end
  end
  initial begin
    logic [25:0] exp_ridx;
    logic flush_chk;
    logic [41:0] e;
    logic [16:0] r;
    exp_ridx = '0;
    flush_chk = 1'b0;
    forever begin
      @(negedge clk);
      if (base_q.size() > 0) exp_ridx = base_q.pop_front();
      if (flush_chk) begin
        check("fifo_flush_after_write", 32'(ad_o), 32'h0);
        flush_chk = 1'b0;
      end
      if (mem_req && mem_ready) begin
        if (mem_we) begin
          if (exp_wr.size() == 0) check("unexpected_write", 32'h1, 32'h0);
          else begin
            e = exp_wr.pop_front();
            check("wr_addr", 32'(mem_addr), 32'(e[41:16]));
            check("wr_data", 32'(mem_wdata), 32'(e[15:0]));
            exp_ridx = e[41:16] + 26'd1;
            flush_chk = 1'b1;
          end
        end else begin
          check("rd_addr", 32'(mem_addr), 32'(exp_ridx));
          exp_ridx = exp_ridx + 26'd1;
        end
      end
      if (exp_rd.size() > 0) begin
        r = exp_rd.pop_front();
        check("ad_oe", 32'(ad_oe), 32'(r[16]));
        check("ad_o", 32'(ad_o), 32'(r[15:0]));
      end
      if (in_miss && (mem_req || ad_oe)) miss_viol++;
    end
  end
  task automatic cyc_n(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic burst(input logic [31:0] a);
    ad_i = a[31:16];
    cyc_n(1);
    ale_h = 1'b0;
    cyc_n(4);
    ad_i = a[15:0];
    cyc_n(1);
    ale_l = 1'b0;
    cyc_n(4);
  endtask
  task automatic end_burst();
    ale_l = 1'b1;
    cyc_n(2);
    ale_h = 1'b1;
    cyc_n(6);
  endtask
  task automatic rd_pulse(input logic [15:0] d, input logic oe);
    read_n = 1'b0;
    cyc_n(5);
    exp_rd.push_back({oe, d});
    cyc_n(2);
    read_n = 1'b1;
    cyc_n(5);
  endtask
  task automatic wr_pulse(input logic [15:0] d);
    ad_i = d;
    write_n = 1'b0;
    cyc_n(4);
    write_n = 1'b1;
    cyc_n(6);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1);
  end
  initial begin
    cyc_n(3);
    check("rst_ad_o", 32'(ad_o), 32'h0);
    check("rst_ad_oe", 32'(ad_oe), 32'h0);
    check("rst_mem_req", 32'(mem_req), 32'h0);
    check("rst_mem_we", 32'(mem_we), 32'h0);
    check("rst_mem_addr", 32'(mem_addr), 32'h0);
    check("rst_mem_wdata", 32'(mem_wdata), 32'h0);
    check("rst_underrun", 32'(underrun), 32'h0);
    resetn = 1'b1;
    cyc_n(4);
    base_q.push_back(26'h0);
    burst(32'h1000_0000);
    cyc_n(10);
    for (int i = 0; i < 4; i++) rd_pulse(exp4[i], 1'b1);
    end_burst();
    in_miss = 1'b1;
    burst(32'h0000_0000);
    repeat (4) rd_pulse(16'h0, 1'b0);
    end_burst();
    in_miss = 1'b0;
    check("miss_quiet", 32'(miss_viol), 32'h0);
    check("miss_no_underrun", 32'(underrun), 32'h0);
    mem_ready = 1'b0;
    base_q.push_back(26'h0);
    burst(32'h1000_0000);
    rd_pulse(16'h0, 1'b1);
    check("underrun_set", 32'(underrun), 32'h1);
    end_burst();
    mem_ready = 1'b1;
    cyc_n(4);
    base_q.push_back(26'h80);
    exp_wr.push_back({26'h80, 16'hBEEF});
    exp_wr.push_back({26'h81, 16'hCAFE});
    burst(32'h1000_0100);
    cyc_n(8);
    wr_pulse(16'hBEEF);
    wr_pulse(16'hCAFE);
    cyc_n(8);
    rd_pulse(16'hA527, 1'b1);
    end_burst();
    check("writes_done", 32'(exp_wr.size()), 32'h0);
    check("underrun_sticky", 32'(underrun), 32'h1);
    lat = 10;
    base_q.push_back(26'h0);
    burst(32'h1000_0000);
    cyc_n(3);
    end_burst();
    base_q.push_back(26'hDA10);
    burst(32'h1001_B420);
    cyc_n(30);
    rd_pulse(16'h7FB5, 1'b1);
    rd_pulse(16'h7FB4, 1'b1);
    end_burst();
    lat = 2;
    cyc_n(20);
    check("underrun_sticky2", 32'(underrun), 32'h1);
    base_q.push_back(26'h0);
    burst(32'h1000_0000);
    cyc_n(10);
    read_n = 1'b0;
    cyc_n(5);
    check("pre_reset_oe", 32'(ad_oe), 32'h1);
    resetn = 1'b0;
    cyc_n(1);
    check("mid_rst_oe", 32'(ad_oe), 32'h0);
    check("mid_rst_req", 32'(mem_req), 32'h0);
    check("mid_rst_underrun", 32'(underrun), 32'h0);
    cyc_n(2);
    resetn = 1'b1;
    cyc_n(1);
    check("post_rst_fifo_empty", 32'(ad_o), 32'h0);
    check("post_rst_req", 32'(mem_req), 32'h0);
    read_n = 1'b1;
    end_burst();
    base_q.push_back(26'h0);
    burst(32'h1000_0000);
    cyc_n(10);
    rd_pulse(16'h1111, 1'b1);
    end_burst();
    cyc_n(4);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
